// File: rtl/div_unit_pkg.sv
// Shared execute-stage control codes and divider state encodings.
// Imported by the divider and its datapath step.
package div_unit_pkg;

   localparam logic [3:0] ALU_ADD_CONTROL = 4'b0010;
   localparam logic [3:0] ALU_SUB_CONTROL = 4'b0110;
   localparam logic [3:0] DIV_CONTROL     = 4'b1010;
   localparam logic [3:0] DIVU_CONTROL    = 4'b1011;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic is_signed_div(input logic [3:0] ctrl);
      return ctrl == DIV_CONTROL;
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration.
// Purely combinational; the caller registers rem/quo each clock.
module div_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;
   logic           borrow;

   // rem < dvs holds between steps, so WIDTH+1 bits are enough
   always_comb begin
      trial  = {rem, quo[WIDTH-1]};
      diff   = trial - {1'b0, dvs};
      borrow = diff[WIDTH];
      rem_nx = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit beside the execute-stage ALU.
// Quotient goes to LO, remainder to HI; one quotient bit per clock.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             busy,
   output logic             result_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_e       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             q_neg;
   logic             r_neg;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic             a_neg;
   logic             b_neg;

   assign busy  = (state != DIV_IDLE);
   assign a_neg = signed_div & dividend[WIDTH-1];
   assign b_neg = signed_div & divisor[WIDTH-1];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem    (rem),
      .quo    (quo),
      .dvs    (dvs),
      .rem_nx (rem_nx),
      .quo_nx (quo_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= DIV_IDLE;
         cnt          <= '0;
         rem          <= '0;
         quo          <= '0;
         dvs          <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         result_valid <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
      end else begin
         result_valid <= 1'b0;
         unique case (state)
            DIV_IDLE: begin
               if (start && !cancel) begin
                  if (divisor == '0) begin
                     quotient     <= '1;
                     remainder    <= dividend;
                     result_valid <= 1'b1;
                     state        <= DIV_DONE;
                  end else begin
                     quo   <= a_neg ? -dividend : dividend;
                     dvs   <= b_neg ? -divisor : divisor;
                     q_neg <= a_neg ^ b_neg;
                     r_neg <= a_neg;
                     rem   <= '0;
                     cnt   <= '0;
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (cancel) begin
                  state <= DIV_IDLE;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + 1'b1;
                  // Last step: publish sign-fixed results
                  if (cnt == LAST) begin
                     quotient     <= q_neg ? -quo_nx : quo_nx;
                     remainder    <= r_neg ? -rem_nx : rem_nx;
                     result_valid <= 1'b1;
                     state        <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for the execute stage of the MIPS pipeline; handles DIV/DIVU.
- The combinational ALU serves single-cycle ops; this block sits beside it and answers execute-stage divide requests over a start/busy/valid handshake.
- It returns quotient (to LO) and remainder (to HI).
- It is radix-2 restoring, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- cancel  input  1  flush (exception/branch squash); aborts the operation in flight.
- busy  output  1  high whenever the state is not IDLE.
- result_valid  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  WIDTH  registered quotient (LO).
- remainder  output  WIDTH  registered remainder (HI).

Behaviour:
- Reset: state IDLE; busy=0, result_valid=0, quotient=0, remainder=0, iteration counter=0. Reset mid-operation discards all work and produces no valid pulse.
- States: IDLE, DIV, DONE.
- IDLE → DIV: start=1, cancel=0, divisor≠0 at edge N.
  - Latch the operands' magnitudes. In signed mode, negate a negative operand.
  - Latch sign flags: q_neg = dividend sign XOR divisor sign; r_neg = dividend sign. Both flags are 0 in unsigned mode.
  - Clear the partial remainder; clear the counter.
- IDLE → DONE (divide by zero): start=1, cancel=0, divisor=0.
  - Set quotient = all-ones and remainder = raw dividend (no sign fixup).
  - result_valid is high in the cycle after edge N.
- DIV: each edge performs one restoring step.
  - Shift {rem, quo} left one bit.
  - Trial-subtract the divisor magnitude from the upper half.
  - If no borrow, keep the difference and set quotient LSB = 1.
  - The counter increments.
- DIV → DONE on the edge that completes step WIDTH (edge N+WIDTH).
  - On that edge, load the quotient/remainder registers with sign-fixed results: negate the quotient if q_neg, negate the remainder if r_neg.
  - result_valid is high in the cycle after edge N+WIDTH. Latency is exactly WIDTH cycles from the start edge.
- DONE → IDLE unconditionally after one cycle. result_valid drops.
- quotient/remainder hold their values until the next completion, reset, or divide-by-zero load. They are not cleared on cancel.
- Overflow, signed 0x80000000 / -1: quotient = 0x80000000, remainder = 0. This falls out of the magnitude path; no special case.
- start in DIV or DONE is ignored. The requester must wait for busy=0.
- cancel in DIV or DONE forces IDLE on the next edge.
  - If cancel lands on the completing DIV edge, no valid pulse is produced and the result registers are not updated.
  - If cancel arrives while in DONE, the already-visible pulse completes; the state returns to IDLE.
- start and cancel high together in IDLE: cancel wins and the request is not accepted.
- busy is combinational from state. It is high in DIV and DONE, including the DONE cycle.

Decomposition:
- Shared defines header, alongside the existing ALU control codes:
  - DIV_CONTROL and DIVU_CONTROL op encodings; the decoder drives signed_div from these.
  - Divider state encodings DIV_IDLE, DIV_BUSY, DIV_DONE.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient shift register, divisor magnitude.
  - Outputs: next remainder, next quotient.
- Top level: FSM, counter, operand/sign latching, final sign fixup.

Test Plan:
- Unsigned 100 / 7: start at edge N → result_valid only in the cycle after edge N+32; quotient=14, remainder=2; busy high exactly edges N..N+33.
- Signed 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Same operands unsigned → quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, no extra cycles.
- Divide by zero, 5 / 0 (either mode) → result_valid in the cycle after the start edge; quotient=0xFFFFFFFF, remainder=5.
- Cancel and back-to-back requests:
  - Start 1000 / 3, assert cancel after 10 DIV cycles → no valid pulse; busy=0 next cycle; prior quotient/remainder unchanged.
  - Then unsigned 0xFFFFFFFF / 0x10 → quotient=0x0FFFFFFF, remainder=0xF.
- Protocol corners:
  - Second start pulsed mid-operation is ignored; the first result is unaffected.
  - start+cancel together in IDLE → busy stays 0.
  - rst asserted mid-DIV → next cycle busy=0, result_valid=0, quotient=0, remainder=0.
